// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload, maskable IRQ.
// Optional feature macro: TC_PRESCALE_EN adds an 8-bit prescaler in CTRL[11:4].
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        auto_reload_s;
    logic        tick_s;
    logic        fsm_irq_set_s;
    logic        fsm_irq_clr_s;
    logic        fsm_en_clr_s;
    logic [31:0] ctrl_rd_s;
    logic        addr_unused_s;

`ifdef TC_PRESCALE_EN
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  psc_q, psc_d;

    assign tick_s    = (psc_q == prescale_q);
    assign ctrl_rd_s = {20'd0, prescale_q, im_q, mode_q, en_q};
`else
    assign tick_s    = 1'b1;
    assign ctrl_rd_s = {28'd0, im_q, mode_q, en_q};
`endif

    // The bridge already decoded the window; only the word offset matters here.
    assign addr_unused_s = ^Addr[31:4];
    assign wr_ctrl_s     = WE && (Addr[3:2] == 2'd0);
    assign wr_preset_s   = WE && (Addr[3:2] == 2'd1);
    assign auto_reload_s = (mode_q == 2'b01);
    assign IRQ           = irq_flag_q & im_q;

    // Countdown state machine: next state, COUNT and the FSM's requests on EN/irq_flag.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        fsm_irq_set_s = 1'b0;
        fsm_irq_clr_s = 1'b0;
        fsm_en_clr_s  = 1'b0;
`ifdef TC_PRESCALE_EN
        psc_d         = psc_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef TC_PRESCALE_EN
                psc_d = 8'd0;
`endif
                if (en_q) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
`ifdef TC_PRESCALE_EN
                psc_d = 8'd0;
`endif
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (tick_s) begin
`ifdef TC_PRESCALE_EN
                    psc_d = 8'd0;
`endif
                    // Terminal test is <= 1 so a PRESET of 0 never wraps COUNT.
                    if (count_q <= 32'd1) begin
                        count_d       = 32'd0;
                        fsm_irq_set_s = 1'b1;
                        state_d       = INT;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end else begin
`ifdef TC_PRESCALE_EN
                    psc_d = psc_q + 8'd1;
`endif
                    count_d = count_q;
                end
            end
            INT: begin
                if (auto_reload_s) begin
                    fsm_irq_clr_s = 1'b1;
                    state_d       = LOAD;
                end else begin
                    fsm_en_clr_s = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register file updates; a CPU write takes priority over the FSM in the same cycle.
    always_comb begin
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;
`ifdef TC_PRESCALE_EN
        prescale_d = prescale_q;
`endif
        if (wr_ctrl_s) begin
            en_d   = Din[0];
            mode_d = Din[2:1];
            im_d   = Din[3];
`ifdef TC_PRESCALE_EN
            prescale_d = Din[11:4];
`endif
        end else if (fsm_en_clr_s) begin
            en_d = 1'b0;
        end else begin
            en_d = en_q;
        end

        if (wr_preset_s) begin
            preset_d = Din;
        end else begin
            preset_d = preset_q;
        end

        if (wr_ctrl_s || wr_preset_s) begin
            irq_flag_d = 1'b0;
        end else if (fsm_irq_set_s) begin
            irq_flag_d = 1'b1;
        end else if (fsm_irq_clr_s) begin
            irq_flag_d = 1'b0;
        end else begin
            irq_flag_d = irq_flag_q;
        end
    end

    // Combinational read mux, no side effects.
    always_comb begin
        case (Addr[3:2])
            2'd0:    Dout = ctrl_rd_s;
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            default: Dout = 32'd0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
`ifdef TC_PRESCALE_EN
            prescale_q <= 8'd0;
            psc_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
`ifdef TC_PRESCALE_EN
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
`endif
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: per-cycle expected COUNT/IRQ pairs are queued
// when a run is started and compared as the cycles elapse.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        Addr = {28'd0, off[3:2]};
        Din  = data;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
        Addr = {28'd0, off[3:2]};
        #1;
        data = Dout;
    endtask

    task automatic read_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(off, v);
        check_val(tag, v, exp);
    endtask

    task automatic sb_push(input logic [31:0] cnt, input logic irq);
        exp_t e;
        e.cnt = cnt;
        e.irq = irq;
        sb_q.push_back(e);
    endtask

    // Advance n cycles, popping one expected COUNT/IRQ pair per cycle.
    task automatic sb_run(input string tag, input int n);
        exp_t        e;
        logic [31:0] c;
        for (int i = 0; i < n; i++) begin
            tick();
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_sb_empty: got no entry, expected one at cycle %0d", tag, i + 1);
            end else begin
                e = sb_q.pop_front();
                bus_read(4'h8, c);
                check_val($sformatf("%s_count_c%0d", tag, i + 1), c, e.cnt);
                check_val($sformatf("%s_irq_c%0d", tag, i + 1), {31'd0, IRQ}, {31'd0, e.irq});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        WE    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 30'd0;
        Din   = 32'd0;
        do_reset();

        // Reset values
        read_check("rst_ctrl", 4'h0, 32'd0);
        read_check("rst_preset", 4'h4, 32'd0);
        read_check("rst_count", 4'h8, 32'd0);
        read_check("rst_off_c", 4'hC, 32'd0);
        check_val("rst_irq", {31'd0, IRQ}, 32'd0);

        // Unimplemented CTRL bits
        bus_write(4'h0, 32'hFFFF_FFF0);
`ifdef TC_PRESCALE_EN
        read_check("ctrl_unimpl", 4'h0, 32'h0000_0FF0);
`else
        read_check("ctrl_unimpl", 4'h0, 32'h0000_0000);
`endif
        do_reset();

        // One-shot, N = 5, IM set
        bus_write(4'h4, 32'd5);
        read_check("os_preset", 4'h4, 32'd5);
        bus_write(4'h0, 32'h9);
        sb_push(32'd0, 1'b0);
        for (int k = 2; k <= 7; k++) sb_push(32'(7 - k), (k == 7));
        sb_push(32'd0, 1'b1);
        sb_push(32'd0, 1'b1);
        sb_run("oneshot", 9);
        read_check("os_ctrl_after", 4'h0, 32'h8);
        bus_write(4'h0, 32'h0);
        check_val("os_irq_drop", {31'd0, IRQ}, 32'd0);
        do_reset();

        // Auto-reload, N = 3: period 5, IRQ pulses at E5, E10, E15
        bus_write(4'h4, 32'd3);
        bus_write(4'h0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            int ph;
            logic [31:0] c;
            ph = (k - 2) % 5;
            if (k < 2)       c = 32'd0;
            else if (ph < 3) c = 32'(3 - ph);
            else             c = 32'd0;
            sb_push(c, (k >= 5) && (k % 5 == 0));
        end
        sb_run("autoreload", 16);

        // Reset in the middle of a count
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_check("midrst_ctrl", 4'h0, 32'd0);
        read_check("midrst_preset", 4'h4, 32'd0);
        read_check("midrst_count", 4'h8, 32'd0);
        check_val("midrst_irq", {31'd0, IRQ}, 32'd0);
        for (int k = 0; k < 3; k++) sb_push(32'd0, 1'b0);
        sb_run("midrst", 3);

        // Stop and resume, N = 100
        bus_write(4'h4, 32'd100);
        bus_write(4'h0, 32'h1);
        sb_push(32'd0, 1'b0);
        for (int k = 2; k <= 62; k++) sb_push(32'(102 - k), 1'b0);
        sb_run("stop", 62);
        // COUNT shows 40 now; EN is still 1 at the write edge, so one more decrement lands.
        bus_write(4'h0, 32'h0);
        for (int k = 0; k < 4; k++) sb_push(32'd39, 1'b0);
        sb_run("frozen", 4);
        bus_write(4'h8, 32'h0000_1234);
        read_check("count_ro", 4'h8, 32'd39);
        bus_write(4'hC, 32'hFFFF_FFFF);
        read_check("off_c_ro", 4'hC, 32'd0);
        bus_write(4'h0, 32'h1);
        sb_push(32'd39, 1'b0);
        sb_push(32'd100, 1'b0);
        sb_push(32'd99, 1'b0);
        sb_run("resume", 3);
        do_reset();

        // Boundary N = 0: interrupt at E3
        bus_write(4'h0, 32'h9);
        sb_push(32'd0, 1'b0);
        sb_push(32'd0, 1'b0);
        sb_push(32'd0, 1'b1);
        sb_push(32'd0, 1'b1);
        sb_run("n0", 4);
        do_reset();

        // Masked one-shot, then setting IM through a CTRL write clears the flag
        bus_write(4'h4, 32'd2);
        bus_write(4'h0, 32'h1);
        sb_push(32'd0, 1'b0);
        sb_push(32'd2, 1'b0);
        sb_push(32'd1, 1'b0);
        sb_push(32'd0, 1'b0);
        sb_push(32'd0, 1'b0);
        sb_push(32'd0, 1'b0);
        sb_run("masked", 6);
        read_check("masked_ctrl", 4'h0, 32'h0);
        bus_write(4'h0, 32'h8);
        for (int k = 0; k < 3; k++) sb_push(32'd0, 1'b0);
        sb_run("unmask", 3);
        read_check("unmask_ctrl", 4'h0, 32'h8);
        do_reset();

        // CTRL write on the INT cycle keeps EN = 1 and restarts the count
        bus_write(4'h4, 32'd2);
        bus_write(4'h0, 32'h9);
        sb_push(32'd0, 1'b0);
        sb_push(32'd2, 1'b0);
        sb_push(32'd1, 1'b0);
        sb_push(32'd0, 1'b1);
        sb_run("collide", 4);
        bus_write(4'h0, 32'h9);
        read_check("collide_ctrl", 4'h0, 32'h9);
        check_val("collide_irq_clr", {31'd0, IRQ}, 32'd0);
        sb_push(32'd0, 1'b0);
        sb_push(32'd2, 1'b0);
        sb_push(32'd1, 1'b0);
        sb_push(32'd0, 1'b1);
        sb_run("rerun", 4);
        do_reset();

`ifdef TC_PRESCALE_EN
        // Prescale P = 1, N = 2: interrupt at E0+6
        bus_write(4'h4, 32'd2);
        bus_write(4'h0, 32'h19);
        sb_push(32'd0, 1'b0);
        sb_push(32'd2, 1'b0);
        sb_push(32'd2, 1'b0);
        sb_push(32'd1, 1'b0);
        sb_push(32'd1, 1'b0);
        sb_push(32'd0, 1'b1);
        sb_push(32'd0, 1'b1);
        sb_run("prescale", 7);
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
